// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES widths, MixColumns FSM states and GF(2^8) helper
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_COL_W   = 32;
    localparam int AES_NCOL    = 4;
    localparam logic [7:0] GF_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mixcol_state_t;

    // Multiply by x in GF(2^8), reducing by x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// rtl/mix_columns_seq_if.sv - valid/ready state-in / state-out bundle for mix_columns_seq
interface mix_columns_seq_if;
    import aes_pkg::*;

    // Column c occupies bits [127-32c -: 32]; byte 0 of each column is its MSB.
    logic                   in_valid;
    logic                   in_ready;
    logic [AES_STATE_W-1:0] in_state;
    logic                   in_skip;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_STATE_W-1:0] out_state;
    logic                   busy;

    modport master (
        output in_valid,
        output in_state,
        output in_skip,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_state,
        input  in_skip,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state,
        output busy
    );

endinterface

// File: rtl/mix.sv
// rtl/mix.sv - combinational 32-bit AES MixColumns column mixer
module mix
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] raw,
    output logic [AES_COL_W-1:0] mixed
);

    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    logic [7:0] w_x0, w_x1, w_x2, w_x3;

    assign w_a0 = raw[31:24];
    assign w_a1 = raw[23:16];
    assign w_a2 = raw[15:8];
    assign w_a3 = raw[7:0];

    assign w_x0 = xtime(w_a0);
    assign w_x1 = xtime(w_a1);
    assign w_x2 = xtime(w_a2);
    assign w_x3 = xtime(w_a3);

    // 3*a is xtime(a) ^ a; rows are 2311 / 1231 / 1123 / 3112.
    assign mixed[31:24] = w_x0 ^ (w_x1 ^ w_a1) ^ w_a2 ^ w_a3;
    assign mixed[23:16] = w_a0 ^ w_x1 ^ (w_x2 ^ w_a2) ^ w_a3;
    assign mixed[15:8]  = w_a0 ^ w_a1 ^ w_x2 ^ (w_x3 ^ w_a3);
    assign mixed[7:0]   = (w_x0 ^ w_a0) ^ w_a1 ^ w_a2 ^ w_x3;

endmodule

// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - time-shares one column mixer over a 128-bit AES state, one column per cycle
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int NCOL  = 4,
    parameter int COL_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    mix_columns_seq_if.slave   bus
);

    localparam int STATE_W = NCOL * COL_W;

    mixcol_state_t      r_state;
    mixcol_state_t      w_state_nxt;
    logic [1:0]         r_col_idx;
    logic [STATE_W-1:0] r_src;
    logic [STATE_W-1:0] r_res;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic [COL_W-1:0]   w_mix_in;
    logic [COL_W-1:0]   w_mix_out;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_state = r_res;
    assign bus.busy      = r_busy;

    always_comb begin
        w_mix_in = '0;
        for (int c = 0; c < NCOL; c++) begin
            if (r_col_idx == c[1:0]) begin
                w_mix_in = r_src[STATE_W-1-c*COL_W -: COL_W];
            end
        end
    end

    mix u_mix (
        .raw   (w_mix_in),
        .mixed (w_mix_out)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = bus.in_skip ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (r_col_idx == 2'd3) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake flags are registered copies of the next state, so they never
    // combinationally depend on in_valid or out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_col_idx   <= 2'd0;
            r_src       <= '0;
            r_res       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt == BUSY) || (w_state_nxt == DONE);
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_src     <= bus.in_state;
                        r_res     <= bus.in_skip ? bus.in_state : '0;
                        r_col_idx <= 2'd0;
                    end
                end
                BUSY: begin
                    for (int c = 0; c < NCOL; c++) begin
                        if (r_col_idx == c[1:0]) begin
                            r_res[STATE_W-1-c*COL_W -: COL_W] <= w_mix_out;
                        end
                    end
                    // Wraps 3 -> 0 on the same edge that enters DONE.
                    r_col_idx <= r_col_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb/tb_mix_columns_seq.sv - self-checking bench for mix_columns_seq
module tb_mix_columns_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mix_columns_seq_if bus();

    mix_columns_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [127:0] din;
        logic         skip;
        logic [127:0] dout;
        int           lat;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic bound_expired(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [7:0] gf_mul(input int a_in, input int b_in);
        int a = a_in;
        int b = b_in;
        int p = 0;
        for (int i = 0; i < 8; i++) begin
            if ((b & 1) != 0) p = p ^ a;
            a = a << 1;
            if ((a & 'h100) != 0) a = a ^ 'h11B;
            b = b >> 1;
        end
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic sk);
        logic [127:0] o;
        int coeff[4];
        logic [7:0] acc;
        coeff = '{2, 3, 1, 1};
        if (sk) return s;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gf_mul(coeff[(k - r + 4) % 4], int'(s[127-32*c-8*k -: 8]));
                end
                o[127-32*c-8*r -: 8] = acc;
            end
        end
        return o;
    endfunction

    task automatic accept(input logic [127:0] st, input logic sk);
        int g;
        g = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_state = st;
        bus.in_skip  = sk;
        while (!bus.in_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (!bus.in_ready) bound_expired("accept");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Returns at a negedge with out_valid high; lat counts rising edges since the handshake cycle.
    task automatic wait_out(output int lat);
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!bus.out_valid) bound_expired("wait_out");
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    logic [127:0] st, exp_v, bv[3];
    logic [127:0] expq[$];
    logic         sk, took, have_acc;
    int           lat, idx, nout, last_acc;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, 128'h8e4da1bc9fdc589d01010101c6c6c6c6, 5};
        tbl[1] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c, 5};
        tbl[2] = '{128'h00112233445566778899aabbccddeeff, 1'b1, 128'h00112233445566778899aabbccddeeff, 1};
        tbl[3] = '{{4{32'hffffffff}},                   1'b0, {4{32'hffffffff}},                   5};

        bus.in_valid  = 1'b0;
        bus.in_state  = '0;
        bus.in_skip   = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        // in_valid asserted under reset must not be latched
        bus.in_valid = 1'b1;
        bus.in_state = 128'hdeadbeef_00000000_12345678_9abcdef0;
        @(negedge clk);
        check("reset_in_ready",  128'(bus.in_ready),  128'(1));
        check("reset_out_valid", 128'(bus.out_valid), 128'(0));
        check("reset_busy",      128'(bus.busy),      128'(0));
        check("reset_out_state", bus.out_state,       128'(0));
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_busy", 128'(bus.busy), 128'(0));

        for (int i = 0; i < 4; i++) begin
            accept(tbl[i].din, tbl[i].skip);
            wait_out(lat);
            check($sformatf("vec%0d_data", i), bus.out_state, tbl[i].dout);
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'(tbl[i].lat));
            check($sformatf("vec%0d_busy", i), 128'(bus.busy), 128'(1));
            ack();
            check($sformatf("vec%0d_valid_drop", i), 128'(bus.out_valid), 128'(0));
            check($sformatf("vec%0d_ready_back", i), 128'(bus.in_ready), 128'(1));
        end

        // Backpressure with stray in_valid pulses during BUSY and DONE
        accept(tbl[1].din, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_state = 128'h0f0e0d0c0b0a09080706050403020100;
        bus.in_skip  = 1'b1;
        wait_out(lat);
        check("bp_latency", 128'(lat), 128'(5));
        for (int k = 0; k < 10; k++) begin
            check("bp_out_valid", 128'(bus.out_valid), 128'(1));
            check("bp_out_state", bus.out_state, tbl[1].dout);
            check("bp_in_ready",  128'(bus.in_ready), 128'(0));
            bus.in_valid = k[0];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_skip  = 1'b0;
        check("bp_final_state", bus.out_state, tbl[1].dout);
        ack();
        check("bp_valid_drop", 128'(bus.out_valid), 128'(0));

        // Reset while BUSY at col_idx=2, with in_valid also high
        accept(tbl[0].din, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_state = tbl[3].din;
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("midrst_in_ready",  128'(bus.in_ready),  128'(1));
        check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
        check("midrst_busy",      128'(bus.busy),      128'(0));
        nout = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.out_valid) nout++;
        end
        check("midrst_no_pulse", 128'(nout), 128'(0));
        accept(tbl[1].din, 1'b0);
        wait_out(lat);
        check("midrst_new_data", bus.out_state, tbl[1].dout);
        check("midrst_new_latency", 128'(lat), 128'(5));
        ack();

        // Randomized transactions against the reference model
        for (int i = 0; i < 10; i++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            sk = 1'($urandom_range(0, 1));
            exp_v = ref_mix(st, sk);
            accept(st, sk);
            wait_out(lat);
            check($sformatf("rand%0d_data", i), bus.out_state, exp_v);
            check($sformatf("rand%0d_latency", i), 128'(lat), sk ? 128'(1) : 128'(5));
            ack();
        end

        // Back-to-back: in_valid held, out_ready held
        for (int i = 0; i < 3; i++) bv[i] = {$urandom, $urandom, $urandom, $urandom};
        idx = 0;
        nout = 0;
        have_acc = 1'b0;
        last_acc = 0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_state  = bv[0];
        bus.in_skip   = 1'b0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && nout < 3; cyc++) begin
            took = 1'b0;
            if (bus.out_valid) begin
                if (expq.size() > 0) check("b2b_data", bus.out_state, expq.pop_front());
                else check("b2b_unexpected_out", 128'(bus.out_valid), 128'(0));
                nout++;
            end
            if (bus.in_valid && bus.in_ready) begin
                if (have_acc) check("b2b_gap_ge6", 128'((cyc - last_acc) >= 6), 128'(1));
                have_acc = 1'b1;
                last_acc = cyc;
                expq.push_back(ref_mix(bv[idx], 1'b0));
                idx++;
                took = 1'b1;
            end
            @(posedge clk);
            #1;
            if (took) begin
                if (idx < 3) bus.in_state = bv[idx];
                else bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_count", 128'(nout), 128'(3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
